ddr2_rd_fifo_ctrl: RTL and testbench
====================================

Name: ddr2_rd_fifo_ctrl

Overview:
- Controller for the 16-deep distributed-RAM read-data FIFO (ddr2_ram_d instance) in the DDR2 read datapath.
- Accepts captured read data words from the capture logic with no backpressure.
- Drives the RAM write/read address bits, write enable and data.
- Presents the RAM's asynchronous dpo output through a registered valid/ready stage to the user read interface.

Parameters:
- DATA_WIDTH, default `MEMORY_WIDTH, word width; must equal the RAM width.
- AFULL_THRESH, default 12, RAM occupancy at or above which afull asserts; legal range 1..15.

Ports:
- wclk  in  1  single clock; also clocks the RAM write port.
- wrst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  capture word valid this cycle; no ready signal returned.
- wr_data  in  DATA_WIDTH  capture word.
- ram_we  out  1  to RAM we.
- ram_d  out  DATA_WIDTH  to RAM d.
- ram_a  out  4  to RAM a3..a0 (bit 0 drives a0).
- ram_dpra  out  4  to RAM dpra3..dpra0.
- ram_dpo  in  DATA_WIDTH  RAM asynchronous read data.
- rd_valid  out  1  rd_data holds a word.
- rd_ready  in  1  consumer accepts the word.
- rd_data  out  DATA_WIDTH  registered output word.
- count  out  5  RAM occupancy 0..16; excludes the output register.
- full  out  1  count == 16.
- afull  out  1  count >= AFULL_THRESH.
- empty  out  1  count == 0 and !rd_valid.
- ovf_err  out  1  sticky overflow flag; see Optional Feature.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - wptr = rptr = 0 (5-bit pointers with wrap bit); count = 0.
  - rd_valid = 0, rd_data = 0, ovf_err = 0.
  - full = 0, afull = 0, empty = 1.
- Write path (combinational):
  - ram_we = wr_en & !full; ram_d = wr_data; ram_a = wptr[3:0].
  - The RAM captures the word at the same wclk edge.
  - wptr increments on each accepted write and wraps from 31 to 0.
- Write while full: word dropped; ram_we = 0; no pointer or count change; overflow event raised.
- Read path:
  - ram_dpra = rptr[3:0].
  - load = (count != 0) & (!rd_valid | rd_ready).
  - On load: rd_data <= ram_dpo; rd_valid <= 1; rptr increments.
  - Else if rd_ready & rd_valid: rd_valid <= 0.
  - rd_data holds its value whenever rd_valid & !rd_ready.
- count:
  - Increments on an accepted write without load.
  - Decrements on load without an accepted write.
  - Unchanged when both or neither occur.
  - Never exceeds 16 or underflows.
- Latency: word written at edge k is visible as rd_valid=1 with that data after edge k+1, provided it reaches the head of the queue.
- Throughput: one word per cycle sustained in both directions.
- Same-address hazard: load is gated on registered count, so the slot being written is never read in the same cycle.
- Full with simultaneous load: the write is still rejected (full is registered-count based). Loss is prevented by keeping AFULL_THRESH margin upstream.
- Output flags full, afull and empty are combinational decodes of registered state; no glitch-sensitive use is allowed.
- Reset mid-operation: all contents discarded; the first post-reset write lands at address 0.

Optional Feature:
- Macro: DDR2_RD_FIFO_OVF_FLAG_EN.
- When defined:
  - ovf_err sets on any write-while-full cycle and stays set until reset.
  - A simulation-only assertion reports each dropped word.
- When undefined: ovf_err is tied to 0 and no overflow-detect logic is generated. Drop behaviour is unchanged.

Decomposition:
- Shared parameters file (DDR2_parameters):
  - FIFO depth constant 16.
  - Pointer width constant 5.
  - `MEMORY_WIDTH.
- One natural sub-module, ddr2_rd_fifo_out_reg: the load/valid/ready output register stage, parameterised by DATA_WIDTH.
- Pointer and count logic stays in the top block.
- The RAM itself is instantiated alongside this block by the parent, not inside it.

Test Plan:
- Reset with wr_en toggling -> all outputs at reset values; empty=1, count=0, ram_we=0.
- Write 0x11,0x22,0x33 on consecutive cycles with rd_ready=1:
  - rd_valid rises the cycle after the first write.
  - Data 0x11,0x22,0x33 on consecutive cycles.
  - count peaks at 1.
- rd_ready=0 and 17 writes of 0x00..0x10:
  - One word in the output register; count reaches 16, full=1.
  - The 18th write (0x11) is dropped; ovf_err=1 with the macro, 0 without.
  - Draining yields 0x00..0x10 in order.
- AFULL_THRESH=12 -> afull asserts on the edge where count goes 11->12 and deasserts on 12->11.
- Continuous write and read for 40 words -> pointers wrap twice; data in order; count stays at or below 1.
- Assert wrst_n low with count=9 and rd_valid=1:
  - count=0, rd_valid=0 immediately.
  - The next write goes to ram_a=0.

Source files
------------

// File: rtl/ddr2_rd_fifo_ctrl_pkg.sv
// Shared constants for the DDR2 read-data FIFO controller.
// Supplies the default word width via `MEMORY_WIDTH when the parent has not defined it.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 16
`endif

package ddr2_rd_fifo_ctrl_pkg;

  localparam int unsigned FifoDepth   = 16;
  localparam int unsigned PtrWidth    = 5;
  localparam int unsigned AddrWidth   = PtrWidth - 1;
  localparam int unsigned CountWidth  = 5;
  localparam int unsigned MemoryWidth = `MEMORY_WIDTH;

  typedef logic [PtrWidth-1:0]   ptr_t;
  typedef logic [CountWidth-1:0] count_t;

  function automatic ptr_t ptr_inc(ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/ddr2_rd_fifo_ctrl_if.sv
// Capture, RAM and user-read signals of the read-data FIFO controller.
// master is the controller side; slave is the surrounding datapath.
interface ddr2_rd_fifo_ctrl_if
  import ddr2_rd_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MemoryWidth
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_d;
  logic [AddrWidth-1:0]  ram_a;
  logic [AddrWidth-1:0]  ram_dpra;
  logic [DATA_WIDTH-1:0] ram_dpo;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  count_t                count;
  logic                  full;
  logic                  afull;
  logic                  empty;
  logic                  ovf_err;

  modport master (
    input  wr_en, wr_data, ram_dpo, rd_ready,
    output ram_we, ram_d, ram_a, ram_dpra, rd_valid, rd_data, count, full, afull, empty,
           ovf_err
  );

  modport slave (
    output wr_en, wr_data, ram_dpo, rd_ready,
    input  ram_we, ram_d, ram_a, ram_dpra, rd_valid, rd_data, count, full, afull, empty,
           ovf_err
  );

endinterface

// File: rtl/ddr2_rd_fifo_out_reg.sv
// Registered valid/ready output stage fed from the RAM's asynchronous read port.
// A word is loaded whenever the RAM holds data and the stage is empty or being drained.
module ddr2_rd_fifo_out_reg #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  avail,
  input  logic [DATA_WIDTH-1:0] dpo,
  input  logic                  rd_ready,
  output logic                  load,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  assign load = avail & (~valid_q | rd_ready);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = dpo;
    end else if (rd_ready && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign rd_valid = valid_q;
  assign rd_data  = data_q;

endmodule

// File: rtl/ddr2_rd_fifo_ctrl.sv
// Pointer/occupancy control for the 16-deep distributed-RAM read-data FIFO.
// Define DDR2_RD_FIFO_OVF_FLAG_EN to build the sticky overflow flag and drop reporting.
module ddr2_rd_fifo_ctrl
  import ddr2_rd_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = MemoryWidth,
  parameter int unsigned AFULL_THRESH = 12
) (
  input logic                 wclk,
  input logic                 wrst_n,
  ddr2_rd_fifo_ctrl_if.master bus
);

  ptr_t   wptr_q, wptr_d;
  ptr_t   rptr_q, rptr_d;
  count_t count_q, count_d;
  logic   full;
  logic   wr_acc;
  logic   load;
  logic   rd_valid;

  assign full   = (count_q == count_t'(FifoDepth));
  // Reset also gates the RAM write so toggling wr_en during reset never touches the array.
  assign wr_acc = bus.wr_en & ~full & wrst_n;

  assign bus.ram_we   = wr_acc;
  assign bus.ram_d    = bus.wr_data;
  assign bus.ram_a    = wptr_q[AddrWidth-1:0];
  assign bus.ram_dpra = rptr_q[AddrWidth-1:0];

  // Load is gated on registered count, so the slot being written is never read this cycle.
  ddr2_rd_fifo_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk      (wclk),
    .rst_n    (wrst_n),
    .avail    (count_q != '0),
    .dpo      (bus.ram_dpo),
    .rd_ready (bus.rd_ready),
    .load     (load),
    .rd_valid (rd_valid),
    .rd_data  (bus.rd_data)
  );

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = ptr_inc(wptr_q);
    if (load)   rptr_d = ptr_inc(rptr_q);
    case ({wr_acc, load})
      2'b10:   count_d = count_q + count_t'(1);
      2'b01:   count_d = count_q - count_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign bus.rd_valid = rd_valid;
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.afull    = (count_q >= count_t'(AFULL_THRESH));
  assign bus.empty    = (count_q == '0) & ~rd_valid;

`ifdef DDR2_RD_FIFO_OVF_FLAG_EN
  logic ovf_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_en && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf_err = ovf_q;

  drop_report: assert property (@(posedge wclk) disable iff (!wrst_n) !(bus.wr_en && full))
    else $warning("ddr2_rd_fifo_ctrl: write while full, word %h dropped", bus.wr_data);
`else
  assign bus.ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr2_rd_fifo_ctrl.sv
// Scoreboarded bench for ddr2_rd_fifo_ctrl with a behavioural 16-entry distributed RAM.
module tb_ddr2_rd_fifo_ctrl;

  localparam int unsigned W = 16;
`ifdef DDR2_RD_FIFO_OVF_FLAG_EN
  localparam int ExpOvf = 1;
`else
  localparam int ExpOvf = 0;
`endif

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;

  ddr2_rd_fifo_ctrl_if #(.DATA_WIDTH(W)) bus ();

  ddr2_rd_fifo_ctrl #(
    .DATA_WIDTH   (W),
    .AFULL_THRESH (12)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  always #5 wclk = ~wclk;

  logic [W-1:0] mem [16];
  always @(posedge wclk) if (bus.ram_we) mem[bus.ram_a] <= bus.ram_d;
  assign bus.ram_dpo = mem[bus.ram_dpra];

  int n_total = 0;
  int n_pass  = 0;
  logic [W-1:0] exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Monitor: each word the consumer takes must be the next one the bench queued.
  always @(negedge wclk) begin
    if (wrst_n && bus.rd_valid && bus.rd_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_data_spurious: got 0x%0h expected no word", bus.rd_data);
      end else begin
        check("rd_data", int'(bus.rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic wr(input logic [W-1:0] d, input bit push);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    if (push) exp_q.push_back(d);
    step();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    int model;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset held while wr_en toggles
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = ~bus.wr_en;
      bus.wr_data = 16'hABCD;
      #1;
      check("reset_ram_we", int'(bus.ram_we), 0);
      step();
    end
    bus.wr_en = 1'b0;
    check("reset_count", int'(bus.count), 0);
    check("reset_empty", int'(bus.empty), 1);
    check("reset_full", int'(bus.full), 0);
    check("reset_afull", int'(bus.afull), 0);
    check("reset_rd_valid", int'(bus.rd_valid), 0);
    check("reset_rd_data", int'(bus.rd_data), 0);
    check("reset_ovf", int'(bus.ovf_err), 0);
    check("reset_ram_a", int'(bus.ram_a), 0);
    wrst_n = 1'b1;
    step();

    // Three back-to-back words with a ready consumer
    bus.rd_ready = 1'b1;
    wr(16'h0011, 1'b1);
    check("lat_valid_low", int'(bus.rd_valid), 0);
    check("lat_count1", int'(bus.count), 1);
    wr(16'h0022, 1'b1);
    check("lat_valid_high", int'(bus.rd_valid), 1);
    check("lat_count2", int'(bus.count), 1);
    wr(16'h0033, 1'b1);
    check("lat_count3", int'(bus.count), 1);
    step();
    check("lat_count4", int'(bus.count), 0);
    check("lat_valid_last", int'(bus.rd_valid), 1);
    step();
    check("lat_empty", int'(bus.empty), 1);

    // Fill to full with consumer stalled; afull tracks occupancy
    bus.rd_ready = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      wr(W'(i), 1'b1);
      model = (i == 0) ? 1 : i;
      check("fill_count", int'(bus.count), model);
      check("fill_afull", int'(bus.afull), int'(model >= 12));
      check("fill_full", int'(bus.full), int'(model == 16));
    end
    check("fill_rd_valid", int'(bus.rd_valid), 1);
    check("fill_rd_data_held", int'(bus.rd_data), 0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h0011;
    #1;
    check("ovf_ram_we", int'(bus.ram_we), 0);
    step();
    bus.wr_en = 1'b0;
    check("ovf_count", int'(bus.count), 16);
    check("ovf_err", int'(bus.ovf_err), ExpOvf);

    // Drain; afull drops on the 12 -> 11 step
    bus.rd_ready = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      step();
      check("drain_count", int'(bus.count), 16 - j);
      check("drain_afull", int'(bus.afull), int'((16 - j) >= 12));
    end
    check("drain_last_valid", int'(bus.rd_valid), 1);
    step();
    check("drain_empty", int'(bus.empty), 1);

    // Sustained streaming across pointer wrap
    for (int i = 0; i < 40; i++) begin
      wr(W'(16'h0100 + i), 1'b1);
      check("stream_count_le1", int'(bus.count <= 5'd1), 1);
    end
    step();
    step();
    check("stream_empty", int'(bus.empty), 1);

    // Reset in the middle of traffic
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 10; i++) wr(W'(16'h0200 + i), 1'b0);
    check("mid_count9", int'(bus.count), 9);
    check("mid_valid", int'(bus.rd_valid), 1);
    #2;
    wrst_n = 1'b0;
    #1;
    check("mid_rst_count", int'(bus.count), 0);
    check("mid_rst_valid", int'(bus.rd_valid), 0);
    check("mid_rst_empty", int'(bus.empty), 1);
    step();
    wrst_n      = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 16'h03C3;
    #1;
    check("post_rst_ram_a", int'(bus.ram_a), 0);
    check("post_rst_ram_we", int'(bus.ram_we), 1);
    exp_q.push_back(16'h03C3);
    bus.rd_ready = 1'b1;
    step();
    bus.wr_en = 1'b0;
    step();
    check("post_rst_valid", int'(bus.rd_valid), 1);
    step();

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
